mealy_mod_counter: RTL
======================

# mealy_mod_counter

Parametrised Mealy event counter: a programmable modulus, up/down direction, an optional rising-edge qualifier on `x`, and a saturating wrap counter. It counts qualifying events on `x` modulo `tc+1` and asserts the Mealy output `z` combinationally in the same cycle as the event that wraps the count. It is the general replacement for the fixed 4-state, up-only, level-sensitive Mealy counter, and sits between an event source and downstream logic that needs a divide-by-N strobe.

## Interface
- `WIDTH`, 4: state register width; modulus up to 2^WIDTH.
- `EDGE_MODE`, 0: 0 means level (each cycle with `x`=1 is an event); 1 means rising edge (`x`=1 and previous-cycle `x`=0).
- `WRAP_W`, 8: width of the saturating wrap counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: count enable; events are ignored when 0.
- `clr` in 1: synchronous clear; priority over counting.
- `dir` in 1: 0 counts up, 1 counts down.
- `tc` in WIDTH: terminal count; modulus is `tc+1`.
- `x` in 1: event input.
- `Sreg` out WIDTH: registered current state.
- `Snext` out WIDTH: combinational next state.
- `z` out 1: Mealy wrap strobe (combinational).
- `wrap_cnt` out WRAP_W: number of wraps, saturating.

## Operation
- Internal register `x_q` samples `x` every cycle, regardless of `en` and `clr`.
- Event definition: `ev = en & x` when `EDGE_MODE`=0; `ev = en & x & ~x_q` when `EDGE_MODE`=1.
- Next-state priority:
  1. `clr`=1: `Snext`=0.
  2. `ev`=0: `Snext`=`Sreg`.
  3. Up, `Sreg`>=`tc`: `Snext`=0 (wrap).
  4. Up, otherwise: `Snext`=`Sreg`+1.
  5. Down, `Sreg`=0: `Snext`=`tc` (wrap).
  6. Down, `Sreg`>`tc`: `Snext`=`tc`, no wrap. This is the out-of-range recovery case.
  7. Down, otherwise: `Snext`=`Sreg`-1.
- `z` = `ev & ~clr & wrap`, where `wrap` is `Sreg`>=`tc` when up and `Sreg`==0 when down.
  - `z` depends on `x` in the current cycle (Mealy), not only on state.
- `wrap_cnt`:
  - `clr`=1: `wrap_cnt`=0.
  - Otherwise it increments when `z`=1, holding at 2^WRAP_W-1.
- `tc`=0 (modulus 1): state stays 0 and every event asserts `z`, in both directions.
- `tc` may change at any time and takes effect on the next evaluation.
  - If `tc` drops below `Sreg` while counting up, the next event wraps to 0 and asserts `z`.
- `dir` may change on any cycle. The next event uses the new direction with no extra latency.
- All arithmetic is unsigned WIDTH-bit. No wrap-around occurs through 2^WIDTH, because the `tc` bound always catches it first.

## Timing
- Reset values (`rst_n`=0, asynchronous): `Sreg`=0, `x_q`=0, `wrap_cnt`=0.
- `Snext`=0 and `z`=0 for the whole time `rst_n` is low.
- First count happens on the first rising `clk` after `rst_n` deasserts, if `ev`=1.
- Latency:
  - `z` and `Snext` are valid combinationally in the event cycle.
  - `Sreg` and `wrap_cnt` update on the following rising edge.
- Reset asserted mid-count: state clears immediately without waiting for `clk`, and no `z` is produced.
- With `EDGE_MODE`=1, an `x` held high across reset deassertion counts once, because `x_q` resets to 0.
- `clr` and `ev` in the same cycle: `clr` wins, `z`=0, and `wrap_cnt` clears.
- `en`=0 with `x`=1: no count and `z`=0, but `x_q` still tracks `x`.

## Test plan
- **Level mode, up count.** WIDTH=2, `tc`=3, `dir`=0, EDGE_MODE=0, `en`=1, `x`=1 for 8 cycles.
  - `Sreg` is 0,1,2,3,0,1,2,3.
  - `z`=1 exactly in the two cycles where `Sreg`=3.
  - `wrap_cnt`=2.
- **Edge mode, down count.** EDGE_MODE=1, `tc`=2, `dir`=1, `x` held high for 5 cycles then pulsed 1-0 three times.
  - The held level counts once: 0→2 with `z`=1.
  - The pulses then give 2→1→0→2, with `z` on the final pulse.
- **Clear priority.** `tc`=5, `Sreg`=5, `ev`=1, `clr`=1.
  - `z`=0, next `Sreg`=0, `wrap_cnt`=0.
- **`tc` lowered mid-count.** `Sreg`=6, `tc` changed to 3.
  - Counting up: next event gives `z`=1 and `Sreg`=0.
  - Counting down from 6: next event gives `Sreg`=3 and `z`=0.
- **Saturation and modulus 1.** WRAP_W=2, `tc`=0, 6 events.
  - `z`=1 on all 6 events, `Sreg` stays 0, `wrap_cnt` saturates at 3.
- **Asynchronous reset mid-count.** Assert `rst_n`=0 between clock edges while `Sreg`=2.
  - `Sreg`=0 and `z`=0 immediately.
  - After release, counting resumes from 0.

Source files
------------

// File: rtl/mealy_mod_counter_if.sv
// mealy_mod_counter_if: control and status bundle for mealy_mod_counter.
//   en, clr, dir, tc, x        : driven by the event source (master)
//   Sreg, Snext, z, wrap_cnt   : driven by the counter (slave)
interface mealy_mod_counter_if #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned WRAP_W = 8
);
   logic              en;
   logic              clr;
   logic              dir;
   logic [WIDTH-1:0]  tc;
   logic              x;
   logic [WIDTH-1:0]  Sreg;
   logic [WIDTH-1:0]  Snext;
   logic              z;
   logic [WRAP_W-1:0] wrap_cnt;

   modport master (
      output en, clr, dir, tc, x,
      input  Sreg, Snext, z, wrap_cnt
   );

   modport slave (
      input  en, clr, dir, tc, x,
      output Sreg, Snext, z, wrap_cnt
   );
endinterface

// File: rtl/mealy_mod_counter.sv
// mealy_mod_counter: programmable-modulus up/down event counter with a Mealy
// wrap strobe and a saturating wrap counter.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of mealy_mod_counter_if
//              in  en, clr, dir, tc, x
//              out Sreg (registered state), Snext (comb next state),
//                  z (comb wrap strobe), wrap_cnt (registered, saturating)
module mealy_mod_counter #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned EDGE_MODE = 0,
   parameter int unsigned WRAP_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mealy_mod_counter_if.slave   bus
);

   localparam logic [WRAP_W-1:0] WRAP_MAX = {WRAP_W{1'b1}};

   logic              r_x_q;
   logic [WIDTH-1:0]  r_sreg;
   logic [WRAP_W-1:0] r_wrap_cnt;

   logic              w_ev;
   logic              w_wrap;
   logic              w_z;
   logic [WIDTH-1:0]  w_snext;

   // Event qualification; gated by rst_n so nothing is produced while in reset
   always_comb begin
      w_ev = bus.en & bus.x & rst_n;
      if (EDGE_MODE != 0) begin
         w_ev = w_ev & ~r_x_q;
      end
   end

   // Wrap condition uses >= when counting up so a lowered tc still wraps
   always_comb begin
      w_wrap = bus.dir ? (r_sreg == '0) : (r_sreg >= bus.tc);
      w_z    = w_ev & ~bus.clr & w_wrap;
   end

   // Next-state selection in priority order
   always_comb begin
      w_snext = r_sreg;
      if (!rst_n) begin
         w_snext = '0;
      end else if (bus.clr) begin
         w_snext = '0;
      end else if (w_ev) begin
         if (!bus.dir) begin
            w_snext = (r_sreg >= bus.tc) ? '0 : r_sreg + WIDTH'(1);
         end else if (r_sreg == '0) begin
            w_snext = bus.tc;
         end else if (r_sreg > bus.tc) begin
            // out-of-range recovery: snap to tc without signalling a wrap
            w_snext = bus.tc;
         end else begin
            w_snext = r_sreg - WIDTH'(1);
         end
      end
   end

   // State, edge-history and wrap-count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x_q      <= 1'b0;
         r_sreg     <= '0;
         r_wrap_cnt <= '0;
      end else begin
         r_x_q  <= bus.x;
         r_sreg <= w_snext;
         if (bus.clr) begin
            r_wrap_cnt <= '0;
         end else if (w_z && (r_wrap_cnt != WRAP_MAX)) begin
            r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
         end
      end
   end

   assign bus.Sreg     = r_sreg;
   assign bus.Snext    = w_snext;
   assign bus.z        = w_z;
   assign bus.wrap_cnt = r_wrap_cnt;

endmodule
